// File: rtl/imem_program_loader_pkg.sv
// ============================================================================
//  Module   : imem_program_loader_pkg
//  Purpose  : Shared constants and state encoding for the instruction-memory
//             program loader and its byte-to-word assembler.
//  Contents : BYTE_BITS, BYTES_PER_WORD, CNT_BITS, HALT_WORD_DEFAULT, state_t
//  Options  : IMEM_LOADER_CHECKSUM_EN adds the ST_CHECK state.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_program_loader_pkg;

   localparam int BYTE_BITS      = 8;
   localparam int BYTES_PER_WORD = 4;
   localparam int CNT_BITS       = 2;

   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      ST_CHECK = 3'd5
`endif
   } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_program_loader_byte_word_assembler.sv
// ============================================================================
//  Module   : imem_program_loader_byte_word_assembler
//  Purpose  : Shifts received bytes in MSB-first and flags the byte that
//             completes a word. The completed word is presented combinationally
//             alongside word_valid so the caller can register it on the same
//             edge that accepts the last byte.
//  Ports    : clk, rst (async, active-low)
//             clear       - synchronous clear of shift register and counter
//             enable      - bytes are only taken while high
//             byte_in     - received byte
//             byte_valid  - byte_in strobe
//             word_out    - word formed by the current byte and prior bytes
//             word_valid  - high when the current byte completes a word
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_program_loader_byte_word_assembler
   import imem_program_loader_pkg::*;
#(
   parameter int NBITS = BYTE_BITS * BYTES_PER_WORD
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [BYTE_BITS-1:0] byte_in,
   input  logic                 byte_valid,
   output logic [NBITS-1:0]     word_out,
   output logic                 word_valid
);

   localparam logic [CNT_BITS-1:0] LAST_BYTE = CNT_BITS'(BYTES_PER_WORD - 1);

   logic [NBITS-1:0]    shift_reg;
   logic [CNT_BITS-1:0] byte_cnt;
   logic                take;

   assign take       = enable & byte_valid;
   assign word_out   = {shift_reg[NBITS-BYTE_BITS-1:0], byte_in};
   assign word_valid = take && (byte_cnt == LAST_BYTE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_reg <= '0;
         byte_cnt  <= '0;
      end else if (clear) begin
         shift_reg <= '0;
         byte_cnt  <= '0;
      end else if (take) begin
         shift_reg <= word_out;
         // Wraps naturally to 0 after the last byte of a word.
         byte_cnt  <= byte_cnt + CNT_BITS'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/imem_program_loader.sv
// ============================================================================
//  Module   : imem_program_loader
//  Purpose  : Writer side of the instruction memory. Assembles 32-bit words
//             from a UART byte stream, writes them sequentially from address 0
//             and holds the CPU until a halt-terminated program is loaded.
//  Ports    : clk, rst (async, active-low)
//             start            - one-cycle pulse, begins a load
//             rx_data/rx_valid - received byte and strobe
//             imem_we/addr/wdata - instruction memory write port (byte addr)
//             cpu_hold         - PC/pipeline write disable
//             busy/done/error  - load status
//             word_count       - words written in current/last load
//  Options  : IMEM_LOADER_CHECKSUM_EN - after the halt word, one more byte is
//             compared with the XOR of every program byte.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_program_loader
   import imem_program_loader_pkg::*;
#(
   parameter int               NBITS     = 32,
   parameter int               ADDR_BITS = 10,
   parameter logic [NBITS-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   output logic                 imem_we,
   output logic [NBITS-1:0]     imem_addr,
   output logic [NBITS-1:0]     imem_wdata,
   output logic                 cpu_hold,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [ADDR_BITS:0]   word_count
);

   localparam logic [ADDR_BITS:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

   state_t             state;
   state_t             state_nxt;
   logic [ADDR_BITS:0] word_index;
   logic [NBITS-1:0]   asm_word;
   logic               word_valid;
   logic               accept;
   logic               is_halt;
   logic               overflow;
   logic               restart;

   // imem_wdata holds the word being written during ST_WRITE, so the halt
   // decision is taken from it rather than from the assembler, which may
   // already be shifting in byte 0 of the next word.
   assign is_halt  = (imem_wdata == HALT_WORD);
   assign overflow = (word_index == DEPTH);
   // Bytes arriving during WRITE belong to the next word, unless the word
   // being written ends the program.
   assign accept   = (state == ST_LOAD) || ((state == ST_WRITE) && !is_halt);
   assign restart  = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                               (state == ST_ERROR));

   imem_program_loader_byte_word_assembler #(
      .NBITS (NBITS)
   ) u_assembler (
      .clk        (clk),
      .rst        (rst),
      .clear      (!accept),
      .enable     (accept),
      .byte_in    (rx_data),
      .byte_valid (rx_valid),
      .word_out   (asm_word),
      .word_valid (word_valid)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] checksum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         checksum <= '0;
      end else if ((state == ST_IDLE) || restart) begin
         checksum <= '0;
      end else if (accept && rx_valid) begin
         checksum <= checksum ^ rx_data;
      end
   end
`endif

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and status outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      error     = 1'b0;
      cpu_hold  = 1'b1;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            busy = 1'b1;
            if (word_valid) state_nxt = overflow ? ST_ERROR : ST_WRITE;
         end
         ST_WRITE: begin
            busy = 1'b1;
            if (is_halt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_nxt = ST_CHECK;
`else
               state_nxt = ST_DONE;
`endif
            end else begin
               state_nxt = ST_LOAD;
            end
         end
         ST_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
            if (start) state_nxt = ST_LOAD;
         end
         ST_ERROR: begin
            error = 1'b1;
            if (start) state_nxt = ST_LOAD;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            busy = 1'b1;
            if (rx_valid) state_nxt = (rx_data == checksum) ? ST_DONE : ST_ERROR;
         end
`endif
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Write port, word index and word counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         word_index <= '0;
         word_count <= '0;
      end else begin
         imem_we <= 1'b0;
         if ((state == ST_IDLE) || restart) begin
            word_index <= '0;
            word_count <= '0;
         end else begin
            // The overflowing word never reaches the memory.
            if ((state == ST_LOAD) && word_valid && !overflow) begin
               imem_we    <= 1'b1;
               imem_addr  <= NBITS'({word_index[ADDR_BITS-1:0], 2'b00});
               imem_wdata <= asm_word;
            end
            if (state == ST_WRITE) begin
               word_count <= word_count + (ADDR_BITS+1)'(1);
               if (!is_halt) word_index <= word_index + (ADDR_BITS+1)'(1);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_program_loader.sv
// ============================================================================
//  Module   : tb_imem_program_loader
//  Purpose  : Scoreboard bench for imem_program_loader. Two instances: a
//             full-depth one (ADDR_BITS=10) and a tiny one (ADDR_BITS=2) for
//             the overflow case. Expected writes are queued by the stimulus
//             and popped by a monitor whenever a DUT asserts imem_we.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_program_loader;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   typedef logic [31:0] word_q_t[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        start0, rxv0, start1, rxv1;
   logic [7:0]  rxd0, rxd1;
   logic        we0, hold0, busy0, done0, err0;
   logic        we1, hold1, busy1, done1, err1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic [10:0] wc0;
   logic [2:0]  wc1;

   imem_program_loader #(.NBITS(32), .ADDR_BITS(10)) dut0 (
      .clk(clk), .rst(rst_n), .start(start0), .rx_data(rxd0), .rx_valid(rxv0),
      .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0), .cpu_hold(hold0),
      .busy(busy0), .done(done0), .error(err0), .word_count(wc0));

   imem_program_loader #(.NBITS(32), .ADDR_BITS(2)) dut1 (
      .clk(clk), .rst(rst_n), .start(start1), .rx_data(rxd1), .rx_valid(rxv1),
      .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1), .cpu_hold(hold1),
      .busy(busy1), .done(done1), .error(err1), .word_count(wc1));

   wr_t q0[$];
   wr_t q1[$];
   int  errors = 0;
   int  checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   always @(negedge clk) begin
      wr_t e;
      if (rst_n === 1'b1) begin
         if (we0 === 1'b1) begin
            if (q0.size() == 0) begin
               checks++; errors++;
               $display("FAIL dut0 unexpected write: addr %h data %h", addr0, wdata0);
            end else begin
               e = q0.pop_front();
               check("dut0 write addr", addr0, e.addr);
               check("dut0 write data", wdata0, e.data);
               check("dut0 write cycle", cyc, e.cyc);
            end
         end
         if (we1 === 1'b1) begin
            if (q1.size() == 0) begin
               checks++; errors++;
               $display("FAIL dut1 unexpected write: addr %h data %h", addr1, wdata1);
            end else begin
               e = q1.pop_front();
               check("dut1 write addr", addr1, e.addr);
               check("dut1 write data", wdata1, e.data);
               check("dut1 write cycle", cyc, e.cyc);
            end
         end
      end
   end

   // ---------------------------------------------------------------- drivers
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int d, input logic s, input logic v, input logic [7:0] b);
      if (d == 0) begin start0 = s; rxv0 = v; rxd0 = b; end
      else        begin start1 = s; rxv1 = v; rxd1 = b; end
   endtask

   task automatic push_exp(input int d, input wr_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Reference model: word k of the program goes to byte address 4*k unless
   // k reaches the memory depth; loading ends after the halt word.
   task automatic run_program(input int d, input int depth, input word_q_t words,
                              input int gapmax, input bit start_midload, input bit good_csum);
      int         n_written = 0;
      bit         halted = 0;
      bit         overflowed = 0;
      bit         exp_done;
      logic [7:0] x = 8'h00;
      logic [7:0] b;
      logic [31:0] w;
      wr_t        e;
      string      p;
      p = (d == 0) ? "dut0" : "dut1";

      drive(d, 1'b1, 1'b0, 8'h00);
      tick;
      drive(d, 1'b0, 1'b0, 8'h00);
      check({p, " busy after start"}, (d == 0) ? busy0 : busy1, 1);

      for (int k = 0; k < words.size(); k++) begin
         w = words[k];
         for (int j = 0; j < 4; j++) begin
            b = 8'(w >> (24 - 8 * j));
            repeat ($urandom_range(0, gapmax)) tick;
            drive(d, start_midload && (k == 0) && (j == 2), 1'b1, b);
            if (k < depth) x ^= b;
            if (j == 3) begin
               if (k >= depth) begin
                  overflowed = 1;
               end else begin
                  e.addr = 32'(k * 4);
                  e.data = w;
                  e.cyc  = cyc + 1;
                  push_exp(d, e);
                  n_written++;
                  halted = (w == HALT);
               end
            end
            tick;
            drive(d, 1'b0, 1'b0, 8'h00);
         end
         if (overflowed || halted) break;
      end

      exp_done = halted;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (halted) begin
         repeat (2) tick;
         drive(d, 1'b0, 1'b1, good_csum ? x : (x ^ 8'h01));
         tick;
         drive(d, 1'b0, 1'b0, 8'h00);
         exp_done = good_csum;
      end
`else
      if (good_csum) exp_done = halted;
`endif
      repeat (3) tick;

      if (d == 0) begin
         check("dut0 done", done0, exp_done);
         check("dut0 error", err0, !exp_done);
         check("dut0 busy", busy0, 0);
         check("dut0 cpu_hold", hold0, !exp_done);
         check("dut0 word_count", wc0, n_written);
         check("dut0 pending writes", q0.size(), 0);
      end else begin
         check("dut1 done", done1, exp_done);
         check("dut1 error", err1, !exp_done);
         check("dut1 busy", busy1, 0);
         check("dut1 cpu_hold", hold1, !exp_done);
         check("dut1 word_count", wc1, n_written);
         check("dut1 pending writes", q1.size(), 0);
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic check_reset0(input string tag);
      check({tag, " cpu_hold"}, hold0, 1);
      check({tag, " busy"}, busy0, 0);
      check({tag, " done"}, done0, 0);
      check({tag, " error"}, err0, 0);
      check({tag, " imem_we"}, we0, 0);
      check({tag, " word_count"}, wc0, 0);
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      word_q_t prog;
      logic [31:0] w;

      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 8'h00);
      drive(1, 1'b0, 1'b0, 8'h00);
      repeat (3) tick;
      rst_n = 1'b1;
      tick;

      check_reset0("reset");
      check("reset imem_addr", addr0, 0);
      check("reset imem_wdata", wdata0, 0);
      check("reset dut1 cpu_hold", hold1, 1);
      check("reset dut1 word_count", wc1, 0);

      // Basic program with gaps between bytes.
      prog = '{32'h2008_0005, HALT};
      run_program(0, 1024, prog, 2, 1'b0, 1'b1);

      // Eight bytes on consecutive cycles.
      prog = '{32'hA1B2_C3D4, HALT};
      run_program(0, 1024, prog, 0, 1'b0, 1'b1);

      // Four-word memory: fifth word overflows.
      prog = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044, 32'h0000_0055};
      run_program(1, 4, prog, 1, 1'b0, 1'b1);

      // Restart from ERROR; halt in the last slot fits exactly.
      prog = '{32'h0000_0009, 32'h0000_0008, 32'h0000_0007, HALT};
      run_program(1, 4, prog, 0, 1'b0, 1'b1);

      // Reset in the middle of a word; stale bytes must not leak.
      drive(0, 1'b1, 1'b0, 8'h00);
      tick;
      drive(0, 1'b0, 1'b1, 8'hAA);
      tick;
      drive(0, 1'b0, 1'b1, 8'hBB);
      tick;
      drive(0, 1'b0, 1'b0, 8'h00);
      rst_n = 1'b0;
      #1;
      check_reset0("mid-load reset");
      tick;
      rst_n = 1'b1;
      tick;
      prog = '{32'h1357_9BDF, 32'h0246_8ACE, HALT};
      run_program(0, 1024, prog, 1, 1'b0, 1'b1);

      // Random programs; one with a start pulse during the load.
      for (int r = 0; r < 6; r++) begin
         prog = {};
         for (int k = 0; k < $urandom_range(1, 5); k++) begin
            w = $urandom;
            if (w == HALT) w = 32'h0;
            prog.push_back(w);
         end
         prog.push_back(HALT);
         run_program(0, 1024, prog, $urandom_range(0, 2), r == 2, (r % 2) == 0);
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      prog = '{32'h0000_0001, HALT};
      run_program(0, 1024, prog, 1, 1'b0, 1'b1);
      run_program(0, 1024, prog, 1, 1'b0, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer side of the instruction-memory interface; the pipelined datapath's fetch stage is the reader.
- Accepts a byte stream from the UART receiver and assembles 32-bit instruction words.
- Writes the words sequentially into instruction memory.
- Holds the CPU pipeline until a program terminated by a halt word has been fully written.

Parameters:
- NBITS, 32, instruction/data word width.
- ADDR_BITS, 10, log2 of instruction memory depth in words.
- HALT_WORD, 32'hFFFF_FFFF, terminating instruction; it is written to memory, then loading ends.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data valid
- imem_we  out  1  instruction memory write enable
- imem_addr  out  NBITS  byte address (word index × 4)
- imem_wdata  out  NBITS  assembled instruction word
- cpu_hold  out  1  holds PC/pipeline (drives datapath PC-write disable)
- busy  out  1  load in progress
- done  out  1  program loaded, halt word written
- error  out  1  load aborted
- word_count  out  ADDR_BITS+1  words written in current/last load, halt word included

Behaviour:
- Clock/reset: one clock, clk. rst is asynchronous, active-low.
- Reset values: state IDLE; imem_we=0; imem_addr=0; imem_wdata=0; cpu_hold=1; busy=0; done=0; error=0; word_count=0; byte counter=0; assembly register=0.
- States: IDLE, LOAD, WRITE, DONE, ERROR; CHECK only when the optional feature is compiled in.
- IDLE:
  - start -> LOAD.
  - Clear byte counter, word index, word_count, assembly register; clear done and error.
  - rx_valid is ignored.
- LOAD:
  - busy=1.
  - Each rx_valid shifts the byte in MSB-first: asm <= {asm[23:0], rx_data}; byte counter increments mod 4.
  - On the 4th byte -> WRITE.
- WRITE (exactly one cycle):
  - imem_we=1, imem_addr=index<<2, imem_wdata=asm; word_count increments.
  - imem_we therefore asserts the cycle after the 4th byte strobe.
  - If asm==HALT_WORD -> DONE (or CHECK). Otherwise index increments -> LOAD.
  - An rx_valid arriving in WRITE is still accepted into byte 0 of the next word, so back-to-back bytes every cycle lose nothing.
- Overflow: if the word index would reach 2^ADDR_BITS without a halt -> ERROR. The overflowing word is not written.
- DONE: done=1, busy=0, cpu_hold=0. The CPU runs from address 0.
- ERROR: error=1, busy=0, cpu_hold=1.
- start in DONE or ERROR: returns to LOAD, clears flags and counters, cpu_hold=1.
- start while busy: ignored.
- Reset mid-load: immediate return to reset values. The partial word is discarded. Already-written memory is not cleared.
- imem_addr and imem_wdata are registered and hold their last value when imem_we=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - After the halt word is written, go to CHECK.
  - The next rx_valid byte is compared against the XOR of all program bytes, halt word included.
  - Match -> DONE. Mismatch -> ERROR.
  - Start pulses are ignored in CHECK.
- Disabled: WRITE of the halt word goes directly to DONE; no checksum logic exists.

Decomposition:
- Shared package:
  - state encoding localparams;
  - HALT_WORD default;
  - byte/word width constants (BYTE_BITS=8, BYTES_PER_WORD=4).
- One natural sub-module, byte_word_assembler:
  - shift register plus 2-bit byte counter;
  - emits a word_valid pulse with the assembled word.
- The FSM, address counter and checksum stay in the top module.

Test Plan:
- Reset, no stimulus -> cpu_hold=1; busy, done, error, imem_we = 0; word_count=0.
- start; bytes 20,08,00,05 then FF×4 -> write addr 0x0 data 0x20080005, then addr 0x4 data 0xFFFFFFFF; done=1, cpu_hold=0, word_count=2.
- Eight bytes on consecutive cycles, no gaps -> both words written correctly; no byte lost; each imem_we exactly one cycle after its 4th byte.
- ADDR_BITS=2; stream 4 non-halt words then a 5th -> 4 writes at 0x0–0xC; 5th not written; error=1, cpu_hold=1.
- rst low after 2 bytes of word 1; release; start; full program -> word 1 assembled only from post-restart bytes; no stale bytes.
- With IMEM_LOADER_CHECKSUM_EN: program 0x00000001 + halt, checksum byte 0x01 -> done=1. Same program with checksum 0x00 -> error=1.
